// File: rtl/bcd_event_counter.sv
// bcd_event_counter: debounced up/down release counter (0..MAX_COUNT) with a
//   sequential double-dabble BCD converter and registered active-low 7-segment drive.
// Latency: accepted release -> o_Count/o_Wrap +2 cycles; count change -> o_BCD/o_BCD_Valid
//   +CW+3 cycles, o_Segments +CW+4 cycles.
// Backpressure: none; a count change while converting is queued (one deep) via pending.
// Ports: i_Clk (posedge), i_Rst (sync, active-high), i_Switch_Up / i_Switch_Down (raw
//   buttons, 1 = pressed), i_Clear (sync clear), o_Count (binary), o_BCD (digit 0 in [3:0]),
//   o_BCD_Valid (pulse), o_Wrap (pulse), o_Segments ({G..A} per digit, digit 0 in [6:0]).
// Config macro LEADING_ZERO_BLANK_EN: blank digits above the most significant nonzero one.
module bcd_event_counter #(
  parameter int NUM_DIGITS      = 2,
  parameter int MAX_COUNT       = 99,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst,
  input  logic                           i_Switch_Up,
  input  logic                           i_Switch_Down,
  input  logic                           i_Clear,
  output logic [$clog2(MAX_COUNT+1)-1:0] o_Count,
  output logic [4*NUM_DIGITS-1:0]        o_BCD,
  output logic                           o_BCD_Valid,
  output logic                           o_Wrap,
  output logic [7*NUM_DIGITS-1:0]        o_Segments
);
  localparam int CW = $clog2(MAX_COUNT+1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES+1);
  localparam int IW = (CW > 1) ? $clog2(CW) : 1;
  localparam int BW = 4*NUM_DIGITS;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES-1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_COUNT);
  localparam logic [IW-1:0] ITER_LAST = IW'(CW-1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  // Debounce + release detect; index 0 = up, 1 = down.
  logic [1:0]    raw;
  logic [1:0]    stable_q, prev_q, ev_q;
  logic [DW-1:0] db_cnt_q [2];

  assign raw = {i_Switch_Down, i_Switch_Up};

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      stable_q <= '0;
      prev_q   <= '0;
      ev_q     <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      prev_q <= stable_q;
      // Registered 1->0 edge of the debounced level, so the count moves two cycles
      // after the release is accepted.
      ev_q   <= prev_q & ~stable_q;
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          // This cycle's increment would reach DEBOUNCE_CYCLES: accept the new level.
          stable_q[i] <= raw[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Count update: clear wins, simultaneous up+down cancel.
  logic [CW-1:0] count_q, count_d;
  logic          wrap_q, wrap_d;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (i_Clear) begin
      count_d = '0;
    end else if (ev_q[0] && !ev_q[1]) begin
      if (count_q == CNT_MAX) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end else if (ev_q[1] && !ev_q[0]) begin
      if (count_q == '0) begin
        count_d = CNT_MAX;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Double-dabble conversion FSM.
  state_t        state_q, state_d;
  logic          pending_q, pending_d;
  logic [CW-1:0] shift_q, shift_d;
  logic [BW-1:0] scratch_q, scratch_d, adj;
  logic [IW-1:0] iter_q, iter_d;
  logic [BW-1:0] bcd_q, bcd_d;
  logic          vld_q, vld_d;
  logic [7*NUM_DIGITS-1:0] seg_q;

  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    // A change in any state is remembered; only IDLE consumes it.
    pending_d = pending_q || (count_d != count_q);
    shift_d   = shift_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    bcd_d     = bcd_q;
    vld_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          state_d   = S_LOAD;
          pending_d = (count_d != count_q);
        end
      end
      S_LOAD: begin
        shift_d   = count_q;
        scratch_d = '0;
        iter_d    = '0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        scratch_d = {adj[BW-2:0], shift_q[CW-1]};
        shift_d   = shift_q << 1;
        iter_d    = iter_q + IW'(1);
        if (iter_q == ITER_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d   = scratch_q;
        vld_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  function automatic logic [6:0] font(input logic [3:0] d);
    case (d)
      4'd0:    font = 7'b1000000;
      4'd1:    font = 7'b1111001;
      4'd2:    font = 7'b0100100;
      4'd3:    font = 7'b0110000;
      4'd4:    font = 7'b0011001;
      4'd5:    font = 7'b0010010;
      4'd6:    font = 7'b0000010;
      4'd7:    font = 7'b1111000;
      4'd8:    font = 7'b0000000;
      4'd9:    font = 7'b0010000;
      default: font = 7'b1111111;
    endcase
  endfunction

  function automatic logic [7*NUM_DIGITS-1:0] seg_of(input logic [BW-1:0] b);
    logic [3:0] dig;
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    seg_of = '0;
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      dig = b[4*i +: 4];
      seg_of[7*i +: 7] = font(dig);
`ifdef LEADING_ZERO_BLANK_EN
      // Walk from the top digit down; zeros stay blank until the first nonzero digit.
      if (dig != 4'd0) lead = 1'b0;
      else if (lead && (i != 0)) seg_of[7*i +: 7] = 7'b1111111;
`endif
    end
  endfunction

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      count_q   <= '0;
      wrap_q    <= 1'b0;
      shift_q   <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      bcd_q     <= '0;
      vld_q     <= 1'b0;
      seg_q     <= seg_of({BW{1'b0}});
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      iter_q    <= iter_d;
      bcd_q     <= bcd_d;
      vld_q     <= vld_d;
      seg_q     <= seg_of(bcd_q);
    end
  end

  assign o_Count     = count_q;
  assign o_Wrap      = wrap_q;
  assign o_BCD       = bcd_q;
  assign o_BCD_Valid = vld_q;
  assign o_Segments  = seg_q;

endmodule

// File: tb/tb_bcd_event_counter.sv
// Testbench for bcd_event_counter (DEBOUNCE_CYCLES=4, NUM_DIGITS=2, MAX_COUNT=99).
// Table of button actions with hand-computed count/wrap/BCD results, plus directed
// sequences for bounce, clear-vs-event priority, reset mid-conversion and back-to-back change.
module tb_bcd_event_counter;
  localparam int ND = 2;
  localparam int MC = 99;
  localparam int DB = 4;
  localparam int CW = 7;

  logic          clk, rst, sw_up, sw_dn, clr;
  logic [CW-1:0] count;
  logic [7:0]    bcd;
  logic          bcd_vld, wrap;
  logic [13:0]   seg;

  bcd_event_counter #(.NUM_DIGITS(ND), .MAX_COUNT(MC), .DEBOUNCE_CYCLES(DB)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Switch_Up(sw_up), .i_Switch_Down(sw_dn), .i_Clear(clr),
    .o_Count(count), .o_BCD(bcd), .o_BCD_Valid(bcd_vld), .o_Wrap(wrap), .o_Segments(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int wrap_seen = 0;
  int vld_seen = 0;

  always @(negedge clk) begin
    if (wrap === 1'b1) wrap_seen++;
    if (bcd_vld === 1'b1) vld_seen++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic       up;
    logic       dn;
    logic       clr;
    int         reps;
    int         exp_count;
    int         exp_wraps;
    int         exp_vlds;
    logic [7:0] exp_bcd;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [6:0] font(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [13:0] exp_seg(input logic [7:0] b);
    logic [6:0] hi, lo;
    lo = font(b[3:0]);
    hi = font(b[7:4]);
`ifdef LEADING_ZERO_BLANK_EN
    if (b[7:4] == 4'd0) hi = 7'b1111111;
`endif
    return {hi, lo};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic u, input logic d);
    sw_up = u;
    sw_dn = d;
    repeat (8) tick();
    sw_up = 1'b0;
    sw_dn = 1'b0;
    repeat (30) tick();
  endtask

  task automatic clear_pulse();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (30) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  int lat;
  int w0, v0, tv, npulse, t2;
  logic found;
  logic [7:0] first_bcd, second_bcd;

  initial begin
    rst = 1'b1; sw_up = 1'b0; sw_dn = 1'b0; clr = 1'b0;
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1,   99, 1, 1,   8'h99};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1,   0,  1, 1,   8'h00};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 42,  42, 0, 42,  8'h42};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1,   42, 0, 0,   8'h42};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 5,   37, 0, 5,   8'h37};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1,   0,  0, 1,   8'h00};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 100, 0,  1, 100, 8'h00};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 7,   7,  0, 7,   8'h07};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 8,   99, 1, 8,   8'h99};

    // Reset state
    repeat (3) tick();
    check("rst_count", count, 0);
    check("rst_bcd", bcd, 0);
    check("rst_vld", bcd_vld, 0);
    check("rst_wrap", wrap, 0);
    check("rst_seg", seg, exp_seg(8'h00));
    rst = 1'b0;
    tick();

    // Bounce rejection: toggling faster than the debounce window, then one clean press.
    v0 = vld_seen;
    for (int i = 0; i < 10; i++) begin
      sw_up = (i % 2 == 0);
      repeat (2) tick();
    end
    sw_up = 1'b1;
    repeat (10) tick();
    sw_up = 1'b0;
    found = 1'b0;
    lat = 6;
    for (int k = 1; k <= 40 && !found; k++) begin
      tick();
      if (count != 0) begin
        found = 1'b1;
        lat = k;
      end
    end
    check("bounce_count_changed", found, 1'b1);
    tv = 0;
    for (int k = 1; k <= 30 && tv == 0; k++) begin
      tick();
      if (bcd_vld) tv = k;
    end
    // LOAD follows the count change by one cycle; valid lands CW+2 after LOAD.
    check("bounce_vld_latency", tv, CW + 3);
    repeat (20) tick();
    check("bounce_count", count, 1);
    check("bounce_bcd", bcd, 8'h01);
    check("bounce_vld_pulses", vld_seen - v0, 1);
    check("bounce_seg", seg, exp_seg(8'h01));

    // Table-driven actions from reset
    do_reset();
    foreach (vecs[i]) begin
      w0 = wrap_seen;
      v0 = vld_seen;
      for (int r = 0; r < vecs[i].reps; r++) begin
        if (vecs[i].clr) clear_pulse();
        else press(vecs[i].up, vecs[i].dn);
      end
      check($sformatf("v%0d_count", i), count, vecs[i].exp_count);
      check($sformatf("v%0d_wraps", i), wrap_seen - w0, vecs[i].exp_wraps);
      check($sformatf("v%0d_vlds", i), vld_seen - v0, vecs[i].exp_vlds);
      check($sformatf("v%0d_bcd", i), bcd, vecs[i].exp_bcd);
      check($sformatf("v%0d_seg", i), seg, exp_seg(vecs[i].exp_bcd));
    end

    // Clear in the same cycle as an up event at count 42
    do_reset();
    for (int r = 0; r < 42; r++) press(1'b1, 1'b0);
    check("clr_pre_count", count, 42);
    w0 = wrap_seen;
    sw_up = 1'b1;
    repeat (8) tick();
    sw_up = 1'b0;
    repeat (lat - 1) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_evt_count", count, 0);
    repeat (30) tick();
    check("clr_evt_count_after", count, 0);
    check("clr_evt_wraps", wrap_seen - w0, 0);
    check("clr_evt_bcd", bcd, 8'h00);

    // Reset during SHIFT
    press(1'b1, 1'b0);
    check("mid_pre_bcd", bcd, 8'h01);
    sw_up = 1'b1;
    repeat (8) tick();
    sw_up = 1'b0;
    repeat (lat) tick();
    check("mid_pre_count", count, 2);
    repeat (3) tick();
    v0 = vld_seen;
    rst = 1'b1;
    tick();
    check("mid_rst_count", count, 0);
    check("mid_rst_bcd", bcd, 0);
    check("mid_rst_vld", bcd_vld, 0);
    check("mid_rst_wrap", wrap, 0);
    check("mid_rst_seg", seg, exp_seg(8'h00));
    rst = 1'b0;
    repeat (30) tick();
    check("mid_no_vld", vld_seen - v0, 0);
    check("mid_post_bcd", bcd, 0);

    // Back-to-back change: clear lands while converting the value 2
    press(1'b1, 1'b0);
    check("b2b_pre_bcd", bcd, 8'h01);
    sw_up = 1'b1;
    repeat (8) tick();
    sw_up = 1'b0;
    repeat (lat) tick();
    check("b2b_count2", count, 2);
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("b2b_count0", count, 0);
    npulse = 0;
    t2 = 0;
    first_bcd = 8'hff;
    second_bcd = 8'hff;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bcd_vld) begin
        if (npulse == 0) first_bcd = bcd;
        else if (npulse == 1) begin
          second_bcd = bcd;
          t2 = k;
        end
        npulse++;
      end
    end
    check("b2b_pulses", npulse, 2);
    check("b2b_first_bcd", first_bcd, 8'h02);
    check("b2b_second_bcd", second_bcd, 8'h00);
    check("b2b_second_in_time", (t2 > 0 && t2 <= 2 * (CW + 3)), 1'b1);
    check("b2b_seg", seg, exp_seg(8'h00));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
